// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbitration logic.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-TX side signals of the transmit arbiter, bundled with
// producer (master) and arbiter (slave) views.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH
);

  localparam int ID_W = $clog2(NUM_REQ);

  // A byte moves on a cycle where valid & ready are both high at the rising edge;
  // the sender holds valid and data stable until then, and ready never waits on valid.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_valid;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_ready;
  logic [NUM_REQ-1:0]            grant;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;
  logic                          abort;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, grant_id, busy, abort
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, grant_id, busy, abort
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, found by masking a doubled copy of the request vector.
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    pick,
  output logic [ID_W-1:0] pick_id,
  output logic            any
);

  localparam int IDX_W = ID_W + 1;

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic [IDX_W-1:0] idx;

  always_comb begin
    dbl    = {req, req};
    // Clearing bits below ptr in the lower copy leaves the upper copy to supply the wrap.
    mask   = ~(({{(2*N-1){1'b0}}, 1'b1} << ptr) - 1'b1);
    masked = dbl & mask;
    idx    = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) idx = IDX_W'(i);
    end
    any     = |req;
    pick_id = (int'(idx) >= N) ? ID_W'(int'(idx) - N) : ID_W'(idx);
    pick    = '0;
    if (any) pick[pick_id] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-aware round-robin owner of the shared UART transmitter, with a
// stall timeout that reclaims the transmitter from a silent owner.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  uart_tx_arbiter_if.slave           bus,
  output arb_state_t                 dbg_state,
  output logic [$clog2(NUM_REQ)-1:0] dbg_ptr
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               abort_q, abort_d;

  logic [NUM_REQ-1:0]    pick;
  logic [ID_W-1:0]       pick_id;
  logic                  pick_any;
  logic                  locked;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  hs;
  logic [ID_W-1:0]       next_ptr;

  rr_picker #(.N(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  assign locked    = (state_q == LOCKED);
  assign own_valid = bus.req_valid[grant_id_q];
  assign own_last  = bus.req_last[grant_id_q];
  assign own_data  = bus.req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
  assign hs        = locked & own_valid & bus.tx_ready;
  assign next_ptr  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    abort_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = LOCKED;
          grant_d    = pick;
          grant_id_d = pick_id;
          cnt_d      = '0;
        end
      end
      LOCKED: begin
        if (hs) begin
          cnt_d = '0;
          if (own_last) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = next_ptr;
          end
        end else if (!own_valid && (TIMEOUT_CYCLES != 0)) begin
          // Only a silent owner ages; a backpressured one is never reclaimed.
          if (cnt_q >= CNT_LAST) begin
            abort_d = 1'b1;
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = next_ptr;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.tx_valid  = locked & own_valid;
  assign bus.tx_data   = locked ? own_data : '0;
  assign bus.req_ready = grant_q & {NUM_REQ{bus.tx_ready}};
  assign bus.grant     = grant_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = locked;
  assign bus.abort     = abort_q;
  assign dbg_state     = state_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte feeders, a tx byte
// scoreboard and hand-computed grant order / cycle spacing.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;

  logic       clk;
  logic       rst;
  arb_state_t dbg_state;
  logic [1:0] dbg_ptr;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [8:0]    src_q[NR][$];
  int            hs_cyc_q[$];
  logic [1:0]    gnt_log[$];
  logic          busy_prev = 1'b0;
  logic [NR-1:0] hs_seen;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // requester feeders: present queue head, pop on observed handshake
  always begin
    @(negedge clk);
    hs_seen = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_data[i*DW +: DW] = src_q[i][0][7:0];
        bus.req_last[i]          = src_q[i][0][8];
      end else begin
        bus.req_valid[i]         = 1'b0;
        bus.req_data[i*DW +: DW] = '0;
        bus.req_last[i]          = 1'b0;
      end
    end
  end

  // tx monitor
  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) begin
      hs_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check_eq("tx_extra_byte", 32'(exp_q.size()), 1);
      else check_eq("tx_data", bus.tx_data, exp_q.pop_front());
    end
    if (bus.busy) check_eq("grant_onehot", bus.grant, 4'b0001 << bus.grant_id);
    if (bus.busy && !busy_prev) gnt_log.push_back(bus.grant_id);
    busy_prev = bus.busy;
  end

  // driver tasks
  task automatic push_src(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_q.push_back(d);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    bus.tx_ready = v;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    clear_queues();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic wait_busy(input int max_cyc);
    int n = 0;
    while (!bus.busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_busy", bus.busy, 1);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_queue", 32'(exp_q.size()), 0);
    check_eq("drain_idle", bus.busy, 0);
  endtask

  task automatic check_spacing(input string tag, input int base, input int n, input int gap_a[]);
    check_eq({tag, "_count"}, 32'(hs_cyc_q.size() - base), 32'(n));
    if (hs_cyc_q.size() - base == n) begin
      for (int k = 1; k < n; k++)
        check_eq({tag, "_gap"}, 32'(hs_cyc_q[base+k] - hs_cyc_q[base+k-1]), 32'(gap_a[k-1]));
    end
  endtask

  // main sequence
  initial begin
    int hb, gb, bad, ab, found;
    int gaps3[] = '{1, 1, 2};
    int gaps8[] = '{2, 2, 2, 2, 2, 2, 2};
    logic [1:0] exp_g8[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_grant", bus.grant, 0);
    check_eq("rst_grant_id", bus.grant_id, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_abort", bus.abort, 0);
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_ptr", dbg_ptr, 0);
    check_eq("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // contention from reset: req0 3-byte packet vs req2 single byte
    set_ready(1'b1);
    @(negedge clk);
    hb = hs_cyc_q.size();
    gb = gnt_log.size();
    push_src(0, 8'h10, 1'b0); push_src(0, 8'h11, 1'b0); push_src(0, 8'h12, 1'b1);
    push_src(2, 8'h20, 1'b1);
    expect_byte(8'h10); expect_byte(8'h11); expect_byte(8'h12); expect_byte(8'h20);
    wait_busy(10);
    wait_drain(40);
    check_spacing("cont", hb, 4, gaps3);
    check_eq("cont_grants", 32'(gnt_log.size() - gb), 2);
    if (gnt_log.size() - gb == 2) begin
      check_eq("cont_first", gnt_log[gb], 0);
      check_eq("cont_second", gnt_log[gb+1], 2);
    end
    check_eq("cont_ptr", dbg_ptr, 3);

    // single request: one-cycle arbitration latency
    @(negedge clk);
    push_src(1, 8'h41, 1'b1);
    expect_byte(8'h41);
    @(negedge clk);
    check_eq("single_not_yet", bus.busy, 0);
    @(negedge clk);
    check_eq("single_grant", bus.grant, 4'b0010);
    check_eq("single_grant_id", bus.grant_id, 1);
    check_eq("single_tx_valid", bus.tx_valid, 1);
    check_eq("single_tx_data", bus.tx_data, 8'h41);
    check_eq("single_req_ready", bus.req_ready, 4'b0010);
    @(negedge clk);
    check_eq("single_idle", bus.busy, 0);
    check_eq("single_grant_clr", bus.grant, 0);
    check_eq("single_id_held", bus.grant_id, 1);
    check_eq("single_ptr", dbg_ptr, 2);

    // backpressure well past the timeout must not abort
    set_ready(1'b0);
    @(negedge clk);
    push_src(0, 8'h55, 1'b1);
    expect_byte(8'h55);
    repeat (2) @(negedge clk);
    check_eq("bp_grant", bus.grant, 4'b0001);
    bad = 0;
    ab  = 0;
    repeat (2000) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h55 || bus.req_ready !== 4'b0000) bad++;
      if (bus.abort) ab++;
    end
    check_eq("bp_stable_bad_cycles", bad, 0);
    check_eq("bp_abort_count", ab, 0);
    set_ready(1'b1);
    wait_drain(10);
    check_eq("bp_ptr", dbg_ptr, 1);

    // timeout: req3 stalls mid-packet, pending req0 follows
    @(negedge clk);
    push_src(3, 8'h31, 1'b0); push_src(3, 8'h32, 1'b0);
    expect_byte(8'h31); expect_byte(8'h32);
    wait_busy(10);
    check_eq("to_owner", bus.grant_id, 3);
    push_src(0, 8'h66, 1'b1);
    expect_byte(8'h66);
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      @(negedge clk);
      if (bus.abort) found = 1;
    end
    check_eq("to_abort_seen", found, 1);
    check_eq("to_abort_delay", 32'(cyc - hs_cyc_q[hs_cyc_q.size()-1]), 17);
    check_eq("to_busy_at_abort", bus.busy, 0);
    check_eq("to_ptr_at_abort", dbg_ptr, 0);
    @(negedge clk);
    check_eq("to_abort_one_cycle", bus.abort, 0);
    check_eq("to_next_grant", bus.grant, 4'b0001);
    wait_drain(10);

    // reset mid-packet
    set_ready(1'b0);
    @(negedge clk);
    push_src(2, 8'h77, 1'b1);
    wait_busy(10);
    check_eq("mid_owner", bus.grant, 4'b0100);
    check_eq("mid_ptr_before", dbg_ptr, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid_grant", bus.grant, 0);
    check_eq("mid_grant_id", bus.grant_id, 0);
    check_eq("mid_busy", bus.busy, 0);
    check_eq("mid_tx_valid", bus.tx_valid, 0);
    check_eq("mid_tx_data", bus.tx_data, 0);
    check_eq("mid_req_ready", bus.req_ready, 0);
    check_eq("mid_abort", bus.abort, 0);
    check_eq("mid_ptr", dbg_ptr, 0);
    clear_queues();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    set_ready(1'b1);
    @(negedge clk);
    push_src(0, 8'h01, 1'b1); push_src(1, 8'h02, 1'b1);
    expect_byte(8'h01); expect_byte(8'h02);
    repeat (2) @(negedge clk);
    check_eq("mid_req0_wins", bus.grant, 4'b0001);
    wait_drain(20);

    // fairness: all requesters stream single-byte packets
    pulse_reset();
    @(negedge clk);
    hb = hs_cyc_q.size();
    gb = gnt_log.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) begin
        push_src(i, 8'(8'h80 + r*16 + i), 1'b1);
        expect_byte(8'(8'h80 + r*16 + i));
      end
    wait_busy(10);
    wait_drain(60);
    check_spacing("fair", hb, 8, gaps8);
    check_eq("fair_grants", 32'(gnt_log.size() - gb), 8);
    if (gnt_log.size() - gb == 8) begin
      for (int k = 0; k < 8; k++) check_eq("fair_order", gnt_log[gb+k], exp_g8[k]);
    end

    repeat (3) @(negedge clk);
    check_eq("end_exp_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
